// File: rtl/hadd_sched_pkg.sv
// hadd_sched_pkg: shared state encoding, default timing and counter sizing
// for the half-adder pulse scheduler.
package hadd_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PULSE_A,
        SEP_WAIT,
        PULSE_B,
        SETUP_WAIT,
        CLK,
        COLLECT,
        DONE
    } state_t;

    localparam int T_SEP_DEF    = 2;
    localparam int T_SETUP_DEF  = 4;
    localparam int T_RESULT_DEF = 8;
    localparam int CNT_W_DEF    = 8;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hadd_pulse_capture.sv
// hadd_pulse_capture: sticky capture of one result line; a second pulse
// inside the same enabled window flags a duplicate.
module hadd_pulse_capture (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_pulse,
    output logic o_hit,
    output logic o_dup
);

    logic r_hit;
    logic r_dup;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hit <= 1'b0;
            r_dup <= 1'b0;
        end else if (i_clr) begin
            r_hit <= 1'b0;
            r_dup <= 1'b0;
        end else if (i_en && i_pulse) begin
            r_hit <= 1'b1;
            r_dup <= r_dup | r_hit;
        end
    end

    assign o_hit = r_hit;
    assign o_dup = r_dup;

endmodule

// File: rtl/hadd_pulse_sched.sv
// hadd_pulse_sched: sequences A/B data pulses, the cell clock pulse and a result
// capture window for one half-adder operation. Optional compare: HADD_SCHED_CHECK_EN.
module hadd_pulse_sched
    import hadd_sched_pkg::*;
#(
    parameter int T_SEP    = T_SEP_DEF,
    parameter int T_SETUP  = T_SETUP_DEF,
    parameter int T_RESULT = T_RESULT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic op_valid,
    output logic op_ready,
    input  logic op_a,
    input  logic op_b,
    output logic a_pulse,
    output logic b_pulse,
    output logic clk_pulse,
    input  logic carry_in,
    input  logic sum_in,
    output logic res_valid,
    input  logic res_ready,
    output logic res_carry,
    output logic res_sum,
    output logic res_err,
    output logic res_mismatch
);

    localparam int CNT_MIN = cnt_width(T_SEP, T_SETUP, T_RESULT);

    generate
        if (CNT_W < CNT_MIN) begin : g_cnt_too_small
            $error("CNT_W cannot hold the largest timing parameter");
        end
    endgenerate

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_a;
    logic             r_b;
    logic             r_a_pulse;
    logic             r_b_pulse;
    logic             r_clk_pulse;
    logic             r_res_valid;
    logic             r_stray;
    logic             r_err_stray;

    logic w_accept;
    logic w_hs;
    logic w_collect;
    logic w_stray_now;
    logic w_cnt_zero;
    logic w_sep;
    logic w_hit_c;
    logic w_hit_s;
    logic w_dup_c;
    logic w_dup_s;

    assign w_accept    = op_valid && (r_state == IDLE);
    assign w_hs        = r_res_valid && res_ready;
    assign w_collect   = (r_state == COLLECT);
    assign w_stray_now = !w_collect && (carry_in || sum_in);
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_sep       = r_a && r_b && (r_state == PULSE_A || r_state == SEP_WAIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_a_pulse   <= 1'b0;
            r_b_pulse   <= 1'b0;
            r_clk_pulse <= 1'b0;
            r_res_valid <= 1'b0;
            r_stray     <= 1'b0;
            r_err_stray <= 1'b0;
        end else begin
            r_a_pulse   <= 1'b0;
            r_b_pulse   <= 1'b0;
            r_clk_pulse <= 1'b0;
            r_stray     <= (r_stray && !w_hs) || w_stray_now;
            case (r_state)
                IDLE: if (op_valid) begin
                    r_a       <= op_a;
                    r_b       <= op_b;
                    r_a_pulse <= op_a;
                    r_b_pulse <= op_b && !op_a;
                    r_cnt     <= (op_a && op_b) ? CNT_W'(T_SEP - 1) : CNT_W'(T_SETUP - 1);
                    r_state   <= PULSE_A;
                end
                // counter times the A->B gap first (both set), then the setup gap
                PULSE_A, SEP_WAIT, PULSE_B, SETUP_WAIT: begin
                    if (w_cnt_zero && w_sep) begin
                        r_state   <= PULSE_B;
                        r_b_pulse <= 1'b1;
                        r_cnt     <= CNT_W'(T_SETUP - 1);
                    end else if (w_cnt_zero) begin
                        r_state     <= CLK;
                        r_clk_pulse <= 1'b1;
                    end else begin
                        r_state <= w_sep ? SEP_WAIT : SETUP_WAIT;
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                CLK: begin
                    r_state <= COLLECT;
                    r_cnt   <= CNT_W'(T_RESULT - 1);
                end
                COLLECT: begin
                    if (w_cnt_zero) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                        r_err_stray <= r_stray;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: if (res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    hadd_pulse_capture u_cap_carry (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_accept),
        .i_en    (w_collect),
        .i_pulse (carry_in),
        .o_hit   (w_hit_c),
        .o_dup   (w_dup_c)
    );

    hadd_pulse_capture u_cap_sum (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_accept),
        .i_en    (w_collect),
        .i_pulse (sum_in),
        .o_hit   (w_hit_s),
        .o_dup   (w_dup_s)
    );

    assign op_ready  = (r_state == IDLE);
    assign a_pulse   = r_a_pulse;
    assign b_pulse   = r_b_pulse;
    assign clk_pulse = r_clk_pulse;
    assign res_valid = r_res_valid;
    assign res_carry = w_hit_c;
    assign res_sum   = w_hit_s;
    assign res_err   = r_res_valid && (w_dup_c || w_dup_s || r_err_stray);

`ifdef HADD_SCHED_CHECK_EN
    logic r_exp_c;
    logic r_exp_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_exp_c <= 1'b0;
            r_exp_s <= 1'b0;
        end else if (w_accept) begin
            r_exp_c <= op_a && op_b;
            r_exp_s <= op_a ^ op_b;
        end
    end

    assign res_mismatch = r_res_valid && ((w_hit_c ^ r_exp_c) || (w_hit_s ^ r_exp_s));
`else
    assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_hadd_pulse_sched.sv
// tb_hadd_pulse_sched: table vectors, reset sequences and randomized operations
// checked cycle by cycle against a schedule computed from the timing rules.
module tb_hadd_pulse_sched;

    localparam int T_SEP    = 2;
    localparam int T_SETUP  = 4;
    localparam int T_RESULT = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic op_valid = 1'b0, op_a = 1'b0, op_b = 1'b0;
    logic carry_in = 1'b0, sum_in = 1'b0, res_ready = 1'b0;
    logic op_ready, a_pulse, b_pulse, clk_pulse;
    logic res_valid, res_carry, res_sum, res_err, res_mismatch;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    hadd_pulse_sched #(
        .T_SEP(T_SEP), .T_SETUP(T_SETUP), .T_RESULT(T_RESULT), .CNT_W(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .a_pulse(a_pulse), .b_pulse(b_pulse), .clk_pulse(clk_pulse),
        .carry_in(carry_in), .sum_in(sum_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_carry(res_carry), .res_sum(res_sum),
        .res_err(res_err), .res_mismatch(res_mismatch)
    );

    function automatic void check(input string nm, input int k, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, k, got, exp);
        end
    endfunction

    function automatic void check_i(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endfunction

    task automatic check_idle_outputs(input string nm);
        check({nm, "_a"}, 0, a_pulse, 1'b0);
        check({nm, "_b"}, 0, b_pulse, 1'b0);
        check({nm, "_clk"}, 0, clk_pulse, 1'b0);
        check({nm, "_rdy"}, 0, op_ready, 1'b1);
        check({nm, "_val"}, 0, res_valid, 1'b0);
        check({nm, "_err"}, 0, res_err, 1'b0);
        check({nm, "_mm"}, 0, res_mismatch, 1'b0);
    endtask

    // One operation: cycle 0 is the accept cycle; cm/sm bit k drives carry/sum in cycle k.
    task automatic run_op(input logic a, input logic b, input logic pre,
                          input logic [31:0] cm, input logic [31:0] sm, input int rdel,
                          output int otc, output int otv,
                          output logic oc, output logic os, output logic oe);
        int tb_c, tc, tv, hs, nc, ns, budget;
        logic stray, ec, es, ee, em, in_res;
        tc = ((a && b) ? 1 + T_SEP : 1) + T_SETUP;
        tb_c = (a && b) ? 1 + T_SEP : (b ? 1 : -1);
        tv = tc + T_RESULT + 1;
        hs = tv + rdel;
        nc = 0;
        ns = 0;
        stray = pre;
        for (int k = 0; k < 32; k++) begin
            if (cm[k]) begin
                if (k > tc && k <= tc + T_RESULT) nc++;
                else stray = 1'b1;
            end
            if (sm[k]) begin
                if (k > tc && k <= tc + T_RESULT) ns++;
                else stray = 1'b1;
            end
        end
        ec = nc > 0;
        es = ns > 0;
        ee = (nc > 1) || (ns > 1) || stray;
        em = (ec != (a && b)) || (es != (a ^ b));
        otc = -1;
        otv = -1;
        oc = 1'b0;
        os = 1'b0;
        oe = 1'b0;
        @(posedge clock);
        #1;
        budget = 0;
        while (!op_ready && budget < 50) begin
            @(posedge clock);
            #1;
            budget++;
        end
        check("idle_wait", budget, op_ready, 1'b1);
        if (pre) begin
            sum_in = 1'b1;
            @(posedge clock);
            #1;
            sum_in = 1'b0;
        end
        for (int k = 0; k <= hs + 1; k++) begin
            op_valid  = (k == 0);
            op_a      = a;
            op_b      = b;
            carry_in  = (k < 32) ? cm[k] : 1'b0;
            sum_in    = (k < 32) ? sm[k] : 1'b0;
            res_ready = (k >= hs);
            @(negedge clock);
            in_res = (k >= tv) && (k <= hs);
            check("a_pulse", k, a_pulse, a && (k == 1));
            check("b_pulse", k, b_pulse, k == tb_c);
            check("clk_pulse", k, clk_pulse, k == tc);
            check("op_ready", k, op_ready, (k == 0) || (k > hs));
            check("res_valid", k, res_valid, in_res);
`ifdef HADD_SCHED_CHECK_EN
            check("res_mismatch", k, res_mismatch, in_res && em);
`else
            check("res_mismatch", k, res_mismatch, 1'b0);
`endif
            if (in_res) begin
                check("res_carry", k, res_carry, ec);
                check("res_sum", k, res_sum, es);
                check("res_err", k, res_err, ee);
            end
            if (clk_pulse && otc < 0) otc = k;
            if (res_valid && otv < 0) begin
                otv = k;
                oc = res_carry;
                os = res_sum;
                oe = res_err;
            end
            @(posedge clock);
            #1;
        end
        op_valid  = 1'b0;
        carry_in  = 1'b0;
        sum_in    = 1'b0;
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic a, b, pre;
        logic [31:0] cm, sm;
        int rdel, tc, tv;
        logic c, s, e;
    } vec_t;

    vec_t vt[8];

    initial begin
        int otc, otv, tc;
        logic oc, os, oe;
        logic [31:0] cm, sm;
        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h0,   0, 7, 16, 1'b1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h200, 0, 5, 14, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   0, 5, 14, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h280, 0, 5, 14, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h200, 0, 5, 14, 1'b0, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h200, 0, 5, 14, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h100, 5, 5, 14, 1'b0, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h400, 0, 7, 16, 1'b0, 1'b1, 1'b0};

        repeat (3) @(negedge clock);
        check_idle_outputs("reset");
        check("reset_carry", 0, res_carry, 1'b0);
        check("reset_sum", 0, res_sum, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].pre, vt[i].cm, vt[i].sm, vt[i].rdel,
                   otc, otv, oc, os, oe);
            check_i($sformatf("vec%0d_clk_cycle", i), otc, vt[i].tc);
            check_i($sformatf("vec%0d_valid_cycle", i), otv, vt[i].tv);
            check($sformatf("vec%0d_carry", i), i, oc, vt[i].c);
            check($sformatf("vec%0d_sum", i), i, os, vt[i].s);
            check($sformatf("vec%0d_err", i), i, oe, vt[i].e);
        end

        // reset asserted during SEP_WAIT of a 1/1 operation
        @(posedge clock);
        #1;
        op_valid = 1'b1;
        op_a = 1'b1;
        op_b = 1'b1;
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        @(negedge clock);
        check("rst_seq_a", 1, a_pulse, 1'b1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_idle_outputs("rst_hold");
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_idle_outputs("rst_after");
        end

        for (int i = 0; i < 40; i++) begin
            logic a, b;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            tc = ((a && b) ? 1 + T_SEP : 1) + T_SETUP;
            cm = '0;
            sm = '0;
            repeat ($urandom_range(0, 2)) cm[$urandom_range(0, tc + T_RESULT)] = 1'b1;
            repeat ($urandom_range(0, 2)) sm[$urandom_range(0, tc + T_RESULT)] = 1'b1;
            run_op(a, b, 1'b0, cm, sm, int'($urandom_range(0, 3)), otc, otv, oc, os, oe);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
